// File: rtl/fp_reservation_station_if.sv
// Issue, CDB and dispatch bus bundle for the FP add/sub reservation station.
// The station uses the slave modport; the issue/CDB/FU side uses master.
interface fp_reservation_station_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int OP_W   = 3
);
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qj;
  logic [TAG_W-1:0]  issue_qk;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_a;
  logic [DATA_W-1:0] disp_b;
  logic [TAG_W-1:0]  disp_tag;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    output cdb_valid, cdb_tag, cdb_data, disp_ready,
    input  issue_ready, issue_tag, disp_valid, disp_op, disp_a, disp_b, disp_tag
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data, disp_ready,
    output issue_ready, issue_tag, disp_valid, disp_op, disp_a, disp_b, disp_tag
  );
endinterface

// File: rtl/fp_reservation_station.sv
// Tomasulo reservation station for the FP add/sub unit: issue, CDB snoop, dispatch, completion.
// Define RS_STATS_EN to build the saturating issue-stall counter on stall_cnt.
module fp_reservation_station #(
  parameter int DATA_W      = 16,
  parameter int TAG_W       = 3,
  parameter int NUM_ENTRIES = 3,
  parameter int RS_ID_BASE  = 1,
  parameter int OP_W        = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  fp_reservation_station_if.slave  bus,
  output logic [1:0]               busy_count,
  output logic [15:0]              stall_cnt
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} state_t;

  state_t            state_q [NUM_ENTRIES];
  state_t            state_d [NUM_ENTRIES];
  logic [OP_W-1:0]   op_q    [NUM_ENTRIES];
  logic [OP_W-1:0]   op_d    [NUM_ENTRIES];
  logic [DATA_W-1:0] vj_q    [NUM_ENTRIES];
  logic [DATA_W-1:0] vj_d    [NUM_ENTRIES];
  logic [DATA_W-1:0] vk_q    [NUM_ENTRIES];
  logic [DATA_W-1:0] vk_d    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qj_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qj_d    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qk_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qk_d    [NUM_ENTRIES];

  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             free_found, ready_found, disp_valid_c;
  logic [IDX_W-1:0] free_idx, ready_idx, sel_idx;
  logic             issue_fire, disp_fire, cdb_hit, byp_j, byp_k;
  logic [3:0]       busy_cnt;

  // Selection is purely from registered state, so a slot freed this cycle is not reused until next.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    busy_cnt    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!free_found && state_q[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!ready_found && state_q[i] == READY) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
      if (state_q[i] != FREE) busy_cnt = busy_cnt + 4'd1;
    end
    sel_idx          = lock_q ? lock_idx_q : ready_idx;
    disp_valid_c     = lock_q || ready_found;
    bus.issue_ready  = free_found;
    bus.issue_tag    = TAG_W'(RS_ID_BASE) + TAG_W'(free_idx);
    bus.disp_valid   = disp_valid_c;
    bus.disp_op      = disp_valid_c ? op_q[sel_idx] : '0;
    bus.disp_a       = disp_valid_c ? vj_q[sel_idx] : '0;
    bus.disp_b       = disp_valid_c ? vk_q[sel_idx] : '0;
    bus.disp_tag     = disp_valid_c ? TAG_W'(RS_ID_BASE) + TAG_W'(sel_idx) : '0;
    busy_count       = busy_cnt[1:0];
  end

  always_comb begin
    issue_fire = bus.issue_valid && free_found;
    disp_fire  = disp_valid_c && bus.disp_ready;
    cdb_hit    = bus.cdb_valid && (bus.cdb_tag != '0);
    byp_j      = cdb_hit && (bus.issue_qj == bus.cdb_tag);
    byp_k      = cdb_hit && (bus.issue_qk == bus.cdb_tag);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      vj_d[i]    = vj_q[i];
      vk_d[i]    = vk_q[i];
      qj_d[i]    = qj_q[i];
      qk_d[i]    = qk_q[i];
      unique case (state_q[i])
        FREE: begin
          if (issue_fire && free_idx == IDX_W'(i)) begin
            op_d[i] = bus.issue_op;
            vj_d[i] = byp_j ? bus.cdb_data : bus.issue_vj;
            vk_d[i] = byp_k ? bus.cdb_data : bus.issue_vk;
            qj_d[i] = byp_j ? '0 : bus.issue_qj;
            qk_d[i] = byp_k ? '0 : bus.issue_qk;
            state_d[i] = (qj_d[i] == '0 && qk_d[i] == '0) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (cdb_hit && qj_q[i] == bus.cdb_tag) begin
            vj_d[i] = bus.cdb_data;
            qj_d[i] = '0;
          end
          if (cdb_hit && qk_q[i] == bus.cdb_tag) begin
            vk_d[i] = bus.cdb_data;
            qk_d[i] = '0;
          end
          if (qj_d[i] == '0 && qk_d[i] == '0) state_d[i] = READY;
        end
        READY: begin
          if (disp_fire && sel_idx == IDX_W'(i)) state_d[i] = EXEC;
        end
        EXEC: begin
          if (cdb_hit && bus.cdb_tag == TAG_W'(RS_ID_BASE + i)) state_d[i] = FREE;
        end
        default: state_d[i] = FREE;
      endcase
    end
  end

  // A stalled dispatch pins its entry until the FU accepts it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= FREE;
        op_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        vj_q[i]    <= vj_d[i];
        vk_q[i]    <= vk_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
      end
      lock_q     <= disp_valid_c && !bus.disp_ready;
      lock_idx_q <= sel_idx;
    end
  end

`ifdef RS_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (bus.issue_valid && !free_found && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fp_reservation_station.sv
// Scoreboard bench for fp_reservation_station: expected dispatches queued at issue, checked at dispatch.
module tb_fp_reservation_station;

  typedef struct {
    logic [2:0]  tag;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0]  busy_count;
  logic [15:0] stall_cnt;
  int compared   = 0;
  int mismatched = 0;
  exp_t sbq[$];

  fp_reservation_station_if bus ();

  fp_reservation_station dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy_count (busy_count),
    .stall_cnt  (stall_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
    bus.issue_vj    = '0;
    bus.issue_vk    = '0;
    bus.issue_qj    = '0;
    bus.issue_qk    = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_data    = '0;
    bus.disp_ready  = 1'b0;
  endtask

  task automatic drive_issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                             input logic [2:0] qj, input logic [2:0] qk);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_vj    = vj;
    bus.issue_vk    = vk;
    bus.issue_qj    = qj;
    bus.issue_qk    = qk;
  endtask

  task automatic cdb_pulse(input logic [2:0] tag, input logic [15:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (bus.issue_ready !== 1'b1 || bus.issue_tag !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL reset_issue got ready=%b tag=%0d want ready=1 tag=1", bus.issue_ready, bus.issue_tag);
    end
    compared++;
    if (bus.disp_valid !== 1'b0 || bus.disp_tag !== 3'd0 || bus.disp_a !== 16'h0 || bus.disp_b !== 16'h0 || bus.disp_op !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_disp got valid=%b tag=%0d a=%h b=%h op=%0d want all zero",
               bus.disp_valid, bus.disp_tag, bus.disp_a, bus.disp_b, bus.disp_op);
    end
    compared++;
    if (busy_count !== 2'd0 || stall_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counts got busy=%0d stall=%0d want 0 0", busy_count, stall_cnt);
    end
  endtask

  // Accepts n dispatches in a row and compares each against the scoreboard front.
  task automatic test_drain(input int n);
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    bus.disp_ready = 1'b1;
    while (got < n && cyc < 20) begin
      if (bus.disp_valid === 1'b1 && sbq.size() > 0) begin
        e = sbq.pop_front();
        compared++;
        if (bus.disp_tag !== e.tag || bus.disp_op !== e.op || bus.disp_a !== e.a || bus.disp_b !== e.b) begin
          mismatched++;
          $display("[TB] FAIL dispatch got tag=%0d op=%0d a=%h b=%h want tag=%0d op=%0d a=%h b=%h",
                   bus.disp_tag, bus.disp_op, bus.disp_a, bus.disp_b, e.tag, e.op, e.a, e.b);
        end
        got++;
      end
      tick();
      cyc++;
    end
    bus.disp_ready = 1'b0;
    compared++;
    if (got != n) begin
      mismatched++;
      $display("[TB] FAIL dispatch_count got %0d want %0d", got, n);
    end
  endtask

  task automatic test_basic();
    drive_issue(3'd1, 16'h3C00, 16'h4000, 3'd0, 3'd0);
    compared++;
    if (bus.issue_tag !== 3'd1 || bus.disp_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_issue got tag=%0d disp_valid=%b want tag=1 disp_valid=0", bus.issue_tag, bus.disp_valid);
    end
    sbq.push_back('{tag: 3'd1, op: 3'd1, a: 16'h3C00, b: 16'h4000});
    tick();
    bus.issue_valid = 1'b0;
    test_drain(1);
    compared++;
    if (bus.disp_valid !== 1'b0 || busy_count !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL basic_exec got disp_valid=%b busy=%0d want 0 1", bus.disp_valid, busy_count);
    end
    cdb_pulse(3'd1, 16'h4200);
    compared++;
    if (busy_count !== 2'd0 || bus.issue_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_complete got busy=%0d ready=%b want 0 1", busy_count, bus.issue_ready);
    end
  endtask

  task automatic test_bypass();
    drive_issue(3'd2, 16'h0000, 16'h5555, 3'd2, 3'd0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd2;
    bus.cdb_data  = 16'h1234;
    sbq.push_back('{tag: 3'd1, op: 3'd2, a: 16'h1234, b: 16'h5555});
    tick();
    bus.issue_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    compared++;
    if (bus.disp_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bypass_ready got disp_valid=%b want 1", bus.disp_valid);
    end
    test_drain(1);
    cdb_pulse(3'd1, 16'h0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      drive_issue(3'(i + 2), 16'h0, 16'(16'h0100 * (i + 1)), 3'd5, 3'd0);
      compared++;
      if (bus.issue_tag !== 3'(i + 1)) begin
        mismatched++;
        $display("[TB] FAIL fill_tag got %0d want %0d", bus.issue_tag, i + 1);
      end
      sbq.push_back('{tag: 3'(i + 1), op: 3'(i + 2), a: 16'hAAAA, b: 16'(16'h0100 * (i + 1))});
      tick();
    end
    compared++;
    if (bus.issue_ready !== 1'b0 || busy_count !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL fill_full got ready=%b busy=%0d want 0 3", bus.issue_ready, busy_count);
    end
    drive_issue(3'd7, 16'hDEAD, 16'hBEEF, 3'd0, 3'd0);
    tick();
    bus.issue_valid = 1'b0;
    compared++;
    if (busy_count !== 2'd3 || bus.disp_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fill_ignored got busy=%0d disp_valid=%b want 3 0", busy_count, bus.disp_valid);
    end
    cdb_pulse(3'd5, 16'hAAAA);
    test_drain(3);
    for (int t = 1; t <= 3; t++) cdb_pulse(3'(t), 16'h0);
    compared++;
    if (busy_count !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL fill_free got busy=%0d want 0", busy_count);
    end
  endtask

  task automatic test_lock();
    drive_issue(3'd5, 16'h0, 16'h1111, 3'd7, 3'd0);
    tick();
    drive_issue(3'd6, 16'h2222, 16'h3333, 3'd0, 3'd0);
    tick();
    bus.issue_valid = 1'b0;
    compared++;
    if (bus.disp_valid !== 1'b1 || bus.disp_tag !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL lock_select got valid=%b tag=%0d want 1 2", bus.disp_valid, bus.disp_tag);
    end
    cdb_pulse(3'd7, 16'h7777);
    compared++;
    if (bus.disp_tag !== 3'd2 || bus.disp_a !== 16'h2222 || bus.disp_op !== 3'd6) begin
      mismatched++;
      $display("[TB] FAIL lock_hold got tag=%0d a=%h op=%0d want 2 2222 6", bus.disp_tag, bus.disp_a, bus.disp_op);
    end
    tick();
    compared++;
    if (bus.disp_tag !== 3'd2 || bus.disp_b !== 16'h3333) begin
      mismatched++;
      $display("[TB] FAIL lock_stable got tag=%0d b=%h want 2 3333", bus.disp_tag, bus.disp_b);
    end
    sbq.push_back('{tag: 3'd2, op: 3'd6, a: 16'h2222, b: 16'h3333});
    sbq.push_back('{tag: 3'd1, op: 3'd5, a: 16'h7777, b: 16'h1111});
    test_drain(2);
    cdb_pulse(3'd1, 16'h0);
    cdb_pulse(3'd2, 16'h0);
  endtask

  task automatic test_stall();
    int exp_stall;
`ifdef RS_STATS_EN
    exp_stall = 10;
`else
    exp_stall = 0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(3'd1, 16'h0, 16'h0, 3'd5, 3'd0);
      tick();
    end
    for (int i = 0; i < 10; i++) tick();
    bus.issue_valid = 1'b0;
    compared++;
    if (stall_cnt !== 16'(exp_stall) || bus.issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_cnt got %0d ready=%b want %0d ready=0", stall_cnt, bus.issue_ready, exp_stall);
    end
    do_reset();
  endtask

  task automatic test_mid_reset();
    drive_issue(3'd3, 16'h0001, 16'h0002, 3'd0, 3'd0);
    tick();
    bus.issue_valid = 1'b0;
    bus.disp_ready  = 1'b1;
    tick();
    bus.disp_ready  = 1'b0;
    drive_issue(3'd4, 16'h0, 16'h0003, 3'd6, 3'd0);
    compared++;
    if (bus.issue_tag !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL mid_tag got %0d want 2", bus.issue_tag);
    end
    tick();
    bus.issue_valid = 1'b0;
    compared++;
    if (busy_count !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL mid_busy got %0d want 2", busy_count);
    end
    reset = 1'b0;
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd6;
    bus.cdb_data  = 16'h9999;
    tick();
    reset = 1'b1;
    bus.cdb_valid = 1'b0;
    compared++;
    if (busy_count !== 2'd0 || bus.disp_valid !== 1'b0 || bus.issue_ready !== 1'b1 ||
        bus.issue_tag !== 3'd1 || bus.disp_a !== 16'h0 || stall_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset got busy=%0d disp_valid=%b ready=%b tag=%0d a=%h stall=%0d want 0 0 1 1 0000 0",
               busy_count, bus.disp_valid, bus.issue_ready, bus.issue_tag, bus.disp_a, stall_cnt);
    end
    tick();
    compared++;
    if (bus.disp_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_no_capture got disp_valid=%b want 0", bus.disp_valid);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_bypass();
    test_fill();
    test_lock();
    test_stall();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
